dot_product_mac: RTL

DOT_PRODUCT_MAC -- requirements
Module: dot_product_mac

---
 rtl/dot_product_mac.sv | 74 +++++++
 1 files changed

// File: rtl/dot_product_mac.sv
// dot_product_mac: signed K-element dot product with a registered product stage.
module dot_product_mac #(
    parameter int W     = 8,
    parameter int K     = 4,
    parameter int ACC_W = 2*W + $clog2(K)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [W-1:0]     a_in,
    input  logic signed [W-1:0]     b_in,
    input  logic                    in_valid,
    output logic                    busy,
    output logic signed [ACC_W-1:0] result,
    output logic                    result_valid
);
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                  state;
    logic signed [2*W-1:0]   prod;
    logic                    prod_valid;
    logic signed [ACC_W-1:0] acc;
    logic [CW-1:0]           cnt;
    logic signed [ACC_W-1:0] prod_ext;

    assign prod_ext = prod;

    // The product captured on one edge is folded into acc on the next, so the
    // final sum is acc + prod_ext at the DRAIN->DONE edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            prod         <= '0;
            prod_valid   <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            prod_valid   <= 1'b0;
            if (prod_valid)
                acc <= acc + prod_ext;
            case (state)
                IDLE: if (start) begin
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ACCUM;
                    busy  <= 1'b1;
                end
                ACCUM: if (in_valid) begin
                    prod       <= a_in * b_in;
                    prod_valid <= 1'b1;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= DRAIN;
                end
                DRAIN: begin
                    result       <= acc + prod_ext;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
